// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse cipher: FSM encoding, the inverse S-box
// and the GF(2^8) multipliers used by InvMixColumns.
package aes_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } fsm_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/inv_mix_columns.sv
// Combinational InvMixColumns over a 128-bit state; byte 0 sits in [127:120],
// columns are four consecutive bytes.
module inv_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;

    assign a0 = din[127 - 32*c -: 8];
    assign a1 = din[119 - 32*c -: 8];
    assign a2 = din[111 - 32*c -: 8];
    assign a3 = din[103 - 32*c -: 8];

    assign dout[127 - 32*c -: 8] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
    assign dout[119 - 32*c -: 8] = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
    assign dout[111 - 32*c -: 8] = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
    assign dout[103 - 32*c -: 8] = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);
  end

endmodule

// File: rtl/inv_cipher_iter.sv
// Iterative AES inverse cipher: one decryption round per clock over a single
// shared round datapath; the final round bypasses InvMixColumns.
module inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          state,
  input  logic [128*(Nr+1)-1:0] w,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          Decrypted_Msg,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  localparam int RW = $clog2(Nr + 1);
  localparam logic [RW-1:0] RND_FIRST = RW'(Nr - 1);
  localparam logic [RW-1:0] RND_ONE   = RW'(1);

  if (!((Nr == 10 && Nk == 4) || (Nr == 12 && Nk == 6) || (Nr == 14 && Nk == 8))) begin : g_bad_cfg
    $error("inv_cipher_iter: unsupported Nr/Nk combination");
  end

  // InvShiftRows: row r rotates right by r, so output column c takes input column c-r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int k = 0; k < 16; k++) begin
      res[127 - 8*k -: 8] = inv_sbox(s[127 - 8*k -: 8]);
    end
    return res;
  endfunction

  fsm_e          fsm, fsm_nxt;
  logic [RW-1:0] rnd, rnd_nxt;
  logic [127:0]  st, st_nxt;

  logic [127:0]  rk_arr [Nr+1];
  logic [127:0]  rk;
  logic [127:0]  ark;
  logic [127:0]  imc;
  logic [127:0]  round_out;

  for (genvar i = 0; i <= Nr; i++) begin : g_rk
    assign rk_arr[i] = w[i*128 +: 128];
  end

  assign rk  = rk_arr[rnd];
  assign ark = inv_sub_bytes(inv_shift_rows(st)) ^ rk;

  inv_mix_columns u_imc (
    .din  (ark),
    .dout (imc)
  );

  assign round_out = (fsm == S_FINAL) ? ark : imc;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high. in_ready is high only in IDLE; out_valid is high only in DONE, and the
  // result holds there, unchanged, until out_ready completes the transfer.
  always_comb begin
    fsm_nxt   = fsm;
    rnd_nxt   = rnd;
    st_nxt    = st;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_nxt  = state ^ rk_arr[Nr];
          rnd_nxt = RND_FIRST;
          fsm_nxt = S_ROUND;
        end
      end
      S_INIT: fsm_nxt = S_ROUND;
      S_ROUND: begin
        st_nxt  = round_out;
        rnd_nxt = rnd - RND_ONE;
        if (rnd == RND_ONE) fsm_nxt = S_FINAL;
      end
      S_FINAL: begin
        st_nxt  = round_out;
        fsm_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_nxt = S_IDLE;
      end
      default: fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= S_IDLE;
      rnd <= '0;
      st  <= '0;
    end else begin
      fsm <= fsm_nxt;
      rnd <= rnd_nxt;
      st  <= st_nxt;
    end
  end

  assign Decrypted_Msg = st;
  assign busy          = (fsm != S_IDLE);
  assign dbg_state     = fsm;

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Directed bench for inv_cipher_iter: FIPS-197 vectors on AES-128 and AES-256
// instances, plus backpressure, mid-round reset and back-to-back jobs.
module tb_inv_cipher_iter;

  localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  logic          a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic          a_in_ready, a_out_valid, a_busy;
  logic [127:0]  a_state = '0, a_msg;
  logic [1407:0] a_w = '0;
  logic [2:0]    a_dbg;

  logic          b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic          b_in_ready, b_out_valid, b_busy;
  logic [127:0]  b_state = '0, b_msg;
  logic [1919:0] b_w = '0;
  logic [2:0]    b_dbg;

  inv_cipher_iter #(.Nr(10), .Nk(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .state(a_state), .w(a_w), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .Decrypted_Msg(a_msg), .busy(a_busy), .dbg_state(a_dbg)
  );

  inv_cipher_iter #(.Nr(14), .Nk(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .state(b_state), .w(b_w), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .Decrypted_Msg(b_msg), .busy(b_busy), .dbg_state(b_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- key schedule model (forward S-box built from GF math) ----------------
  logic [7:0] sbox_tb [256];
  logic [1919:0] w_b, w_c1, w_c3;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_tb[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox_tb[t[31:24]], sbox_tb[t[23:16]], sbox_tb[t[15:8]], sbox_tb[t[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0]   wd [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] res;
    rc  = 8'h01;
    res = '0;
    for (int i = 0; i < 60; i++) wd[i] = '0;
    for (int i = 0; i < nk; i++) wd[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = wd[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      wd[i] = wd[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      res[r*128 +: 128] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
    return res;
  endfunction

  // ---------------- driver: one job on dut_a (sel=0) or dut_b (sel=1) ----------------
  task automatic run_job(input bit sel, input logic [127:0] ct, input logic [1919:0] wk,
                         input logic [127:0] exp_pt, input int exp_lat, input string name);
    int cyc;
    int lat;
    logic [127:0] got;
    @(negedge clk);
    if (sel) begin b_state = ct; b_w = wk; b_in_valid = 1'b1; b_out_ready = 1'b1; end
    else     begin a_state = ct; a_w = wk[1407:0]; a_in_valid = 1'b1; a_out_ready = 1'b1; end
    cyc = 0;
    while (!(sel ? b_in_ready : a_in_ready) && cyc < 40) begin @(negedge clk); cyc++; end
    n_cmp++;
    if (cyc >= 40) begin
      n_bad++;
      $display("FAIL %s accept: in_ready=0 after %0d cycles, required 1", name, cyc);
      a_in_valid = 1'b0; b_in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    // ciphertext must already be captured, so scramble it
    if (sel) begin b_in_valid = 1'b0; b_state = ~ct; end
    else     begin a_in_valid = 1'b0; a_state = ~ct; end
    cyc = 0;
    while (!(sel ? b_out_valid : a_out_valid) && cyc < 60) begin
      @(posedge clk); cyc++; @(negedge clk);
    end
    lat = cyc + 1;
    got = sel ? b_msg : a_msg;
    n_cmp++;
    if (got !== exp_pt) begin
      n_bad++; $display("FAIL %s plaintext: got %h required %h", name, got, exp_pt);
    end
    n_cmp++;
    if (lat !== exp_lat) begin
      n_bad++; $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ((sel ? b_busy : a_busy) !== 1'b0) begin
      n_bad++; $display("FAIL %s idle_after: busy=%b required 0", name, sel ? b_busy : a_busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset a.in_ready: got %b required 1", a_in_ready); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset a.out_valid: got %b required 0", a_out_valid); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset a.busy: got %b required 0", a_busy); end
    n_cmp++; if (a_msg !== 128'h0) begin n_bad++; $display("FAIL reset a.msg: got %h required 0", a_msg); end
    n_cmp++; if (b_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset b.in_ready: got %b required 1", b_in_ready); end
    n_cmp++; if (b_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset b.out_valid: got %b required 0", b_out_valid); end
    n_cmp++; if (b_busy !== 1'b0) begin n_bad++; $display("FAIL reset b.busy: got %b required 0", b_busy); end
    n_cmp++; if (b_msg !== 128'h0) begin n_bad++; $display("FAIL reset b.msg: got %h required 0", b_msg); end
    rst_n = 1'b1;
  endtask

  task automatic test_fips_b();
    run_job(1'b0, CT_B, w_b, PT_B, 11, "fips_b");
  endtask

  task automatic test_fips_c1();
    run_job(1'b0, CT_C1, w_c1, PT_C, 11, "fips_c1");
  endtask

  task automatic test_aes256();
    run_job(1'b1, CT_C3, w_c3, PT_C, 15, "aes256_c3");
  endtask

  task automatic test_backpressure();
    int cyc;
    @(negedge clk);
    a_state = CT_C1; a_w = w_c1[1407:0]; a_in_valid = 1'b1; a_out_ready = 1'b0;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bp start in_ready: got %b required 1", a_in_ready); end
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0; a_state = CT_B;
    repeat (2) @(negedge clk);
    a_in_valid = 1'b1;
    n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL bp busy in_ready: got %b required 0", a_in_ready); end
    n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL bp busy: got %b required 1", a_busy); end
    @(negedge clk);
    a_in_valid = 1'b0;
    cyc = 0;
    while (!a_out_valid && cyc < 40) begin @(negedge clk); cyc++; end
    n_cmp++; if (cyc >= 40) begin n_bad++; $display("FAIL bp out_valid: still 0 after %0d cycles, required 1", cyc); end
    for (int i = 0; i < 20; i++) begin
      a_in_valid = (i < 5);
      n_cmp++; if (a_msg !== PT_C) begin n_bad++; $display("FAIL bp hold msg[%0d]: got %h required %h", i, a_msg, PT_C); end
      n_cmp++; if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL bp hold out_valid[%0d]: got %b required 1", i, a_out_valid); end
      n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL bp hold in_ready[%0d]: got %b required 0", i, a_in_ready); end
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL bp release out_valid: got %b required 0", a_out_valid); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bp release in_ready: got %b required 1", a_in_ready); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL bp release busy: got %b required 0", a_busy); end
  endtask

  task automatic test_reset_mid_round();
    @(negedge clk);
    a_state = CT_B; a_w = w_b[1407:0]; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid busy before: got %b required 1", a_busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid out_valid: got %b required 0", a_out_valid); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid in_ready: got %b required 1", a_in_ready); end
    n_cmp++; if (a_msg !== 128'h0) begin n_bad++; $display("FAIL rst_mid msg: got %h required 0", a_msg); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid busy: got %b required 0", a_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    test_fips_c1();
  endtask

  task automatic test_back_to_back();
    int acc, got, cyc;
    int t_out [2];
    logic [127:0] res [2];
    acc = 0; got = 0; cyc = 0;
    t_out[0] = 0; t_out[1] = 0; res[0] = '0; res[1] = '0;
    a_out_ready = 1'b1;
    while (got < 2 && cyc < 200) begin
      @(negedge clk);
      if (a_out_valid) begin res[got] = a_msg; t_out[got] = cyc; got++; end
      a_w        = (got == 0 || (got == 1 && a_out_valid)) ? w_b[1407:0] : w_c1[1407:0];
      a_state    = (acc == 0) ? CT_B : CT_C1;
      a_in_valid = (acc < 2);
      if (a_in_valid && a_in_ready) acc++;
      cyc++;
    end
    a_in_valid = 1'b0;
    n_cmp++; if (got !== 2) begin n_bad++; $display("FAIL b2b count: got %0d results required 2", got); end
    n_cmp++; if (res[0] !== PT_B) begin n_bad++; $display("FAIL b2b first: got %h required %h", res[0], PT_B); end
    n_cmp++; if (res[1] !== PT_C) begin n_bad++; $display("FAIL b2b second: got %h required %h", res[1], PT_C); end
    n_cmp++; if (t_out[1] - t_out[0] !== 12) begin n_bad++; $display("FAIL b2b spacing: got %0d required 12", t_out[1] - t_out[0]); end
    @(negedge clk);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    init_sbox();
    w_b  = expand({KEY_B, 128'h0}, 4, 10);
    w_c1 = expand({KEY_C1, 128'h0}, 4, 10);
    w_c3 = expand(KEY_C3, 8, 14);
    test_reset();
    test_fips_b();
    test_fips_c1();
    test_aes256();
    test_backpressure();
    test_reset_mid_round();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
